// File: rtl/pixel_sink_pkg.sv
// Shared constants, payload type and helpers for the pixel sink.
package pixel_sink_pkg;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;
    localparam int unsigned FB_WORDS = SCREEN_W * SCREEN_H;
    localparam int unsigned COLOR_W  = 3;
    localparam int unsigned ADDR_W   = 15;
    localparam int unsigned X_W      = 8;
    localparam int unsigned Y_W      = 7;
    localparam int unsigned DROP_W   = 8;

    localparam logic [COLOR_W-1:0] BLACK = 3'b000;
    localparam logic [COLOR_W-1:0] WHITE = 3'b111;

    // One buffered frame-memory write.
    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [COLOR_W-1:0] color;
    } pix_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // y*160 + x built from shifts: y*128 + y*32 + x.
    function automatic logic [ADDR_W-1:0] lin_addr(input logic [X_W-1:0] x,
                                                   input logic [Y_W-1:0] y);
        return (ADDR_W'(y) << 7) + (ADDR_W'(y) << 5) + ADDR_W'(x);
    endfunction

endpackage

// File: rtl/pixel_sink_fifo.sv
// Synchronous FIFO of pixel writes.
// Ports: clk, resetn (sync, active low), i_push/i_din, i_pop/o_dout (head),
//        o_full, o_empty. Push on full and pop on empty are not allowed.
module pixel_fifo
    import pixel_sink_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_push,
    input  pix_t i_din,
    input  logic i_pop,
    output pix_t o_dout,
    output logic o_full,
    output logic o_empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    pix_t             r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    // Storage carries no reset; only pointers and occupancy do.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + PTR_W'(1);
            if (i_pop)  r_rptr <= r_rptr + PTR_W'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_dout  = r_mem[r_rptr];
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/pixel_sink.sv
// Pixel sink: clips drawer pixels, buffers them, linearises to y*160+x and
// drives the frame memory write port; also performs full-screen clears.
// Ports: clk, resetn (sync, active low); drawer side writeEn/x_in/y_in/
//        color_in with in_ready; clear_go/clear_color with clear_done pulse;
//        memory side mem_we/mem_addr/mem_data with mem_ready; drop_count.
module pixel_sink
    import pixel_sink_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               writeEn,
    input  logic [X_W-1:0]     x_in,
    input  logic [Y_W-1:0]     y_in,
    input  logic [COLOR_W-1:0] color_in,
    output logic               in_ready,
    input  logic               clear_go,
    input  logic [COLOR_W-1:0] clear_color,
    output logic               clear_done,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [COLOR_W-1:0] mem_data,
    input  logic               mem_ready,
    output logic [DROP_W-1:0]  drop_count
);

    state_t             r_state;
    state_t             w_next;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [COLOR_W-1:0] r_data;
    logic               r_clear_done;
    logic [COLOR_W-1:0] r_clr_color;
    logic [DROP_W-1:0]  r_drop;

    logic w_full;
    logic w_empty;
    logic w_accept;
    logic w_clip;
    logic w_push;
    logic w_load;
    logic w_pop;
    pix_t w_din;
    pix_t w_head;

    assign in_ready = (r_state == ST_IDLE) && !w_full;
    assign w_accept = writeEn && in_ready;
    assign w_clip   = (x_in >= X_W'(SCREEN_W)) || (y_in >= Y_W'(SCREEN_H));
    assign w_push   = w_accept && !w_clip;
    assign w_din    = '{addr: lin_addr(x_in, y_in), color: color_in};

    // Output register may take a new entry when empty or completing.
    assign w_load = !r_we || mem_ready;
    assign w_pop  = ((r_state == ST_IDLE) || (r_state == ST_DRAIN)) && w_load && !w_empty;

    pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_push  (w_push),
        .i_din   (w_din),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (clear_go) w_next = ST_DRAIN;
            ST_DRAIN: if (w_empty && w_load) w_next = ST_CLEAR;
            ST_CLEAR: if (mem_ready && (r_addr == ADDR_W'(FB_WORDS - 1))) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Output transaction register, clear counter (reuses r_addr) and drop counter.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
            r_clear_done <= 1'b0;
            r_clr_color  <= '0;
            r_drop       <= '0;
        end else begin
            r_clear_done <= 1'b0;
            if (w_accept && w_clip && (r_drop != {DROP_W{1'b1}})) begin
                r_drop <= r_drop + DROP_W'(1);
            end
            if ((r_state == ST_IDLE) && clear_go) begin
                r_clr_color <= clear_color;
            end
            case (r_state)
                ST_IDLE, ST_DRAIN: begin
                    if ((r_state == ST_DRAIN) && (w_next == ST_CLEAR)) begin
                        r_we   <= 1'b1;
                        r_addr <= '0;
                        r_data <= r_clr_color;
                    end else if (w_load) begin
                        r_we <= !w_empty;
                        if (!w_empty) begin
                            r_addr <= w_head.addr;
                            r_data <= w_head.color;
                        end
                    end
                end
                ST_CLEAR: begin
                    if (mem_ready) begin
                        if (r_addr == ADDR_W'(FB_WORDS - 1)) begin
                            r_we         <= 1'b0;
                            r_clear_done <= 1'b1;
                        end else begin
                            r_addr <= r_addr + ADDR_W'(1);
                        end
                    end
                end
                default: r_we <= 1'b0;
            endcase
        end
    end

    assign mem_we     = r_we;
    assign mem_addr   = r_addr;
    assign mem_data   = r_data;
    assign clear_done = r_clear_done;
    assign drop_count = r_drop;

endmodule
